pc_gen_ras: RTL and testbench
=============================

Name: pc_gen_ras

Overview:
- Registered next-PC generator for the superscalar front end; owns the fetch PC register.
- Selects the next fetch-group address by fixed priority: EX correction, F-stage predicted branch, jump, return, sequential.
- Holds a parametrised-depth return address stack (RAS) for return prediction.
- Latches an EX redirect that arrives during a stall and applies it when the stall releases.
- Feeds the fetch stage; EX redirects come from the branch unit.

Parameters:
- WIDTH, 32, address width.
- FETCH_WIDTH, 2, instructions per fetch group; power of 2, at least 1. Group size is 4*FETCH_WIDTH bytes.
- RESET_PC, 32'h0000_0000, PC loaded on reset; aligned to the group size.
- RAS_DEPTH, 4, number of RAS entries; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  fetch stall; PC holds
- branch_en_EX  in  1  EX resolved a predicted branch this cycle
- branch_correction  in  1  with branch_en_EX: 1 = prediction was wrong, fall through; 0 = redirect to target
- branch_EX  in  WIDTH  EX branch target
- normal_EX  in  WIDTH  EX fall-through address
- branch_en_F  in  1  F-stage predicted-taken branch
- branch_F  in  WIDTH  predicted target
- jump_en  in  1  F-stage direct jump
- jump  in  WIDTH  jump target
- call_en  in  1  current group contains a call; push ret_addr
- ret_addr  in  WIDTH  return address to push
- ret_en  in  1  current group contains a return; pop
- pc_out  out  WIDTH  current fetch PC
- ex_redirect  out  1  one-cycle pulse: PC was loaded from an EX source (flush request)
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - pc_out=RESET_PC, ex_redirect=0.
  - Pending-redirect valid cleared; RAS count=0, top pointer=0, ras_empty=1, ras_full=0.
  - Reset overrides every other input in the same cycle, including mid-stall and pending-redirect states.
- Sequential next PC: (pc_out with low log2(4*FETCH_WIDTH) bits cleared) + 4*FETCH_WIDTH, modulo 2^WIDTH. Wraps from the top group to 0.
- EX target when branch_en_EX=1: normal_EX if branch_correction=1, else branch_EX.
- Priority when not stalled (first match wins):
  - 1) branch_en_EX=1 -> EX target; ex_redirect=1 next cycle.
  - 2) pending valid -> pending address; ex_redirect=1; pending cleared.
  - 3) branch_en_F -> branch_F.
  - 4) jump_en -> jump.
  - 5) ret_en and RAS not empty -> RAS top.
  - 6) otherwise sequential, including ret_en with an empty RAS.
- All PC updates are registered; latency is 1 cycle from inputs to pc_out.
- Stall=1:
  - pc_out holds; ex_redirect=0.
  - F-stage inputs, call_en and ret_en are ignored; the fetch stage re-presents them.
  - branch_en_EX during stall writes its EX target into the pending register. A later EX redirect during the same stall overwrites it (newest wins).
  - On the first non-stall cycle the pending address is used unless a new branch_en_EX is present; that new redirect wins and also clears pending.
- RAS updates only in non-stalled cycles and only when priorities 1-2 did not fire. An EX redirect cycle squashes that group's call_en/ret_en.
  - Push: entry[top+1]=ret_addr; top++; count=min(count+1, RAS_DEPTH). When full, the oldest entry is overwritten (circular wrap) and ras_full stays 1.
  - Pop: allowed only if count>0. The read value is used as the next PC; top--; count--. A pop when empty is a no-op with a sequential PC.
  - Simultaneous push and pop (call and return in one group): the pop value is read first, then ret_addr overwrites the same top entry; top and count are unchanged. If the RAS is empty, only the push happens.
  - Pointer arithmetic is modulo RAS_DEPTH.
  - EX redirects do not repair the RAS.
- Inputs may assert simultaneously; only the priority above determines the result.

Test Plan:
- Reset, FETCH_WIDTH=2, RESET_PC=0; run 4 cycles with no inputs -> pc_out 0x0, 0x8, 0x10, 0x18, 0x20. With pc_out=0xFFFF_FFF8 -> next pc_out is 0x0.
- One cycle with branch_en_EX=1, branch_correction=0, branch_EX=0x100, plus branch_en_F=1, branch_F=0x200 -> pc_out=0x100, ex_redirect=1 for exactly one cycle. Same stimulus with branch_correction=1, normal_EX=0x44 -> pc_out=0x44.
- Stall for 3 cycles; branch_EX=0x300 in stall cycle 1, then 0x340 in stall cycle 2 -> pc_out held throughout; after release pc_out=0x340 with an ex_redirect pulse. Repeat with a fresh branch_EX=0x380 in the release cycle -> 0x380, and pending cleared.
- RAS_DEPTH=4: push 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_full=1. Five returns -> next PCs 0x50, 0x40, 0x30, 0x20, then sequential; ras_empty=1 after the 4th pop.
- Call and return in the same group with top=0x20 -> next PC 0x20; top becomes ret_addr; count unchanged. ret_en while jump_en=1 -> PC=jump, RAS unchanged.
- Assert rst while stalled with a pending redirect and RAS count=3 -> next cycle pc_out=RESET_PC, pending cleared, ras_empty=1, ex_redirect=0.

Source files
------------

// File: rtl/pc_gen_ras.sv
// rtl/pc_gen_ras.sv - registered next-PC generator with return address stack
// Fixed-priority fetch PC selection with a stall-held EX redirect and a circular RAS.
module pc_gen_ras #(
  parameter int               WIDTH       = 32,
  parameter int               FETCH_WIDTH = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             branch_en_EX,
  input  logic             branch_correction,
  input  logic [WIDTH-1:0] branch_EX,
  input  logic [WIDTH-1:0] normal_EX,
  input  logic             branch_en_F,
  input  logic [WIDTH-1:0] branch_F,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump,
  input  logic             call_en,
  input  logic [WIDTH-1:0] ret_addr,
  input  logic             ret_en,
  output logic [WIDTH-1:0] pc_out,
  output logic             ex_redirect,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam logic [WIDTH-1:0] GROUP_INC = WIDTH'(4 * FETCH_WIDTH);
  localparam int               PTR_W     = $clog2(RAS_DEPTH);
  localparam int               CNT_W     = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             ex_redirect_q, ex_redirect_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic             ras_we;
  logic [PTR_W-1:0] ras_widx;
  logic [WIDTH-1:0] ex_target;
  logic [WIDTH-1:0] seq_pc;
  logic [PTR_W-1:0] top_inc;
  logic             do_pop;

  assign ex_target = branch_correction ? normal_EX : branch_EX;
  assign seq_pc    = (pc_q & ~(GROUP_INC - 1'b1)) + GROUP_INC;
  assign top_inc   = top_q + 1'b1;

  always_comb begin
    pc_d          = pc_q;
    ex_redirect_d = 1'b0;
    pend_valid_d  = pend_valid_q;
    pend_addr_d   = pend_addr_q;
    top_d         = top_q;
    cnt_d         = cnt_q;
    ras_we        = 1'b0;
    ras_widx      = top_q;
    do_pop        = 1'b0;

    if (stall) begin
      if (branch_en_EX) begin
        pend_valid_d = 1'b1;
        pend_addr_d  = ex_target;
      end
    end else if (branch_en_EX) begin
      pc_d          = ex_target;
      ex_redirect_d = 1'b1;
      pend_valid_d  = 1'b0;
    end else if (pend_valid_q) begin
      pc_d          = pend_addr_q;
      ex_redirect_d = 1'b1;
      pend_valid_d  = 1'b0;
    end else begin
      // A return only pops when it actually supplies the next PC.
      do_pop = !branch_en_F && !jump_en && ret_en && (cnt_q != '0);

      if (branch_en_F)  pc_d = branch_F;
      else if (jump_en) pc_d = jump;
      else if (do_pop)  pc_d = ras_q[top_q];
      else              pc_d = seq_pc;

      if (call_en && do_pop) begin
        ras_we   = 1'b1;
        ras_widx = top_q;
      end else if (call_en) begin
        ras_we   = 1'b1;
        ras_widx = top_inc;
        top_d    = top_inc;
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      end else if (do_pop) begin
        top_d = top_q - 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      ex_redirect_q <= 1'b0;
      pend_valid_q  <= 1'b0;
      pend_addr_q   <= '0;
      top_q         <= '0;
      cnt_q         <= '0;
    end else begin
      pc_q          <= pc_d;
      ex_redirect_q <= ex_redirect_d;
      pend_valid_q  <= pend_valid_d;
      pend_addr_q   <= pend_addr_d;
      top_q         <= top_d;
      cnt_q         <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ras_we && !rst) ras_q[ras_widx] <= ret_addr;
  end

  assign pc_out      = pc_q;
  assign ex_redirect = ex_redirect_q;
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_pc_gen_ras.sv
// tb/tb_pc_gen_ras.sv - directed scoreboard bench for pc_gen_ras
// Stimulus queues hand-computed expectations tagged with the cycle they fall due.
module tb_pc_gen_ras;

  logic        clk = 1'b0;
  logic        rst, stall, branch_en_EX, branch_correction, branch_en_F, jump_en, call_en, ret_en;
  logic [31:0] branch_EX, normal_EX, branch_F, jump, ret_addr;
  logic [31:0] pc_out;
  logic        ex_redirect, ras_empty, ras_full;

  pc_gen_ras #(.WIDTH(32), .FETCH_WIDTH(2), .RESET_PC(32'h0), .RAS_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_en_EX(branch_en_EX), .branch_correction(branch_correction),
    .branch_EX(branch_EX), .normal_EX(normal_EX),
    .branch_en_F(branch_en_F), .branch_F(branch_F),
    .jump_en(jump_en), .jump(jump),
    .call_en(call_en), .ret_addr(ret_addr), .ret_en(ret_en),
    .pc_out(pc_out), .ex_redirect(ex_redirect),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    string       name;
    logic [31:0] pc;
    logic        exr;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (e.due < cyc_cnt) begin
        n_bad++;
        $display("FAIL %s: expectation missed (due %0d, now %0d)", e.name, e.due, cyc_cnt);
      end else if (pc_out !== e.pc || ex_redirect !== e.exr ||
                   ras_empty !== e.empty || ras_full !== e.full) begin
        n_bad++;
        $display("FAIL %s: got pc=%h exr=%b empty=%b full=%b, want pc=%h exr=%b empty=%b full=%b",
                 e.name, pc_out, ex_redirect, ras_empty, ras_full, e.pc, e.exr, e.empty, e.full);
      end
    end
  end

  task automatic clear_in();
    stall = 0; branch_en_EX = 0; branch_correction = 0; branch_en_F = 0;
    jump_en = 0; call_en = 0; ret_en = 0;
    branch_EX = '0; normal_EX = '0; branch_F = '0; jump = '0; ret_addr = '0;
  endtask

  // Inputs already driven; expect the given outputs after the next edge, then clear inputs.
  task automatic cyc(input string name, input logic [31:0] pc, input logic exr,
                     input logic empty, input logic full);
    exp_t e;
    e.due = cyc_cnt + 1; e.name = name; e.pc = pc; e.exr = exr; e.empty = empty; e.full = full;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    clear_in();
  endtask

  initial begin
    clear_in();
    rst = 1;
    cyc("reset", 32'h0, 0, 1, 0);
    rst = 0;
    cyc("seq1", 32'h08, 0, 1, 0);
    cyc("seq2", 32'h10, 0, 1, 0);
    cyc("seq3", 32'h18, 0, 1, 0);
    cyc("seq4", 32'h20, 0, 1, 0);

    jump_en = 1; jump = 32'hFFFF_FFF8;
    cyc("jump_top", 32'hFFFF_FFF8, 0, 1, 0);
    cyc("wrap", 32'h0, 0, 1, 0);
    cyc("seq5", 32'h08, 0, 1, 0);

    branch_en_EX = 1; branch_EX = 32'h100; branch_en_F = 1; branch_F = 32'h200;
    cyc("ex_over_f", 32'h100, 1, 1, 0);
    cyc("exr_pulse_end", 32'h108, 0, 1, 0);
    branch_en_EX = 1; branch_correction = 1; normal_EX = 32'h44; branch_EX = 32'h100;
    branch_en_F = 1; branch_F = 32'h200;
    cyc("ex_correct", 32'h44, 1, 1, 0);
    cyc("seq_unaligned", 32'h48, 0, 1, 0);

    stall = 1; branch_en_EX = 1; branch_EX = 32'h300;
    cyc("stall1", 32'h48, 0, 1, 0);
    stall = 1; branch_en_EX = 1; branch_EX = 32'h340;
    cyc("stall2", 32'h48, 0, 1, 0);
    stall = 1; branch_en_F = 1; branch_F = 32'h990; ret_en = 1;
    cyc("stall3", 32'h48, 0, 1, 0);
    cyc("pend_apply", 32'h340, 1, 1, 0);
    cyc("pend_cleared", 32'h348, 0, 1, 0);

    stall = 1; branch_en_EX = 1; branch_EX = 32'h300;
    cyc("stall_b1", 32'h348, 0, 1, 0);
    stall = 1;
    cyc("stall_b2", 32'h348, 0, 1, 0);
    branch_en_EX = 1; branch_EX = 32'h380;
    cyc("release_new_ex", 32'h380, 1, 1, 0);
    cyc("pend_dropped", 32'h388, 0, 1, 0);

    call_en = 1; ret_addr = 32'h10; cyc("push10", 32'h390, 0, 0, 0);
    call_en = 1; ret_addr = 32'h20; cyc("push20", 32'h398, 0, 0, 0);
    call_en = 1; ret_addr = 32'h30; cyc("push30", 32'h3A0, 0, 0, 0);
    call_en = 1; ret_addr = 32'h40; cyc("push40", 32'h3A8, 0, 0, 1);
    call_en = 1; ret_addr = 32'h50; cyc("push50_wrap", 32'h3B0, 0, 0, 1);
    ret_en = 1; cyc("pop50", 32'h50, 0, 0, 0);
    ret_en = 1; cyc("pop40", 32'h40, 0, 0, 0);
    ret_en = 1; cyc("pop30", 32'h30, 0, 0, 0);
    ret_en = 1; cyc("pop20", 32'h20, 0, 1, 0);
    ret_en = 1; cyc("pop_empty", 32'h28, 0, 1, 0);

    call_en = 1; ret_addr = 32'h10; cyc("push10b", 32'h30, 0, 0, 0);
    call_en = 1; ret_addr = 32'h20; cyc("push20b", 32'h38, 0, 0, 0);
    call_en = 1; ret_en = 1; ret_addr = 32'h77;
    cyc("call_ret", 32'h20, 0, 0, 0);
    ret_en = 1; cyc("pop77", 32'h77, 0, 0, 0);
    ret_en = 1; cyc("pop10b", 32'h10, 0, 1, 0);

    call_en = 1; ret_addr = 32'h60; cyc("push60", 32'h18, 0, 0, 0);
    ret_en = 1; jump_en = 1; jump = 32'h500;
    cyc("jump_over_ret", 32'h500, 0, 0, 0);
    ret_en = 1; cyc("pop60", 32'h60, 0, 1, 0);
    call_en = 1; ret_en = 1; ret_addr = 32'h90;
    cyc("call_ret_empty", 32'h68, 0, 0, 0);
    ret_en = 1; cyc("pop90", 32'h90, 0, 1, 0);

    branch_en_EX = 1; branch_EX = 32'h600; call_en = 1; ret_addr = 32'h11;
    cyc("ex_squash_call", 32'h600, 1, 1, 0);

    call_en = 1; ret_addr = 32'hA; cyc("pushA", 32'h608, 0, 0, 0);
    call_en = 1; ret_addr = 32'hB; cyc("pushB", 32'h610, 0, 0, 0);
    call_en = 1; ret_addr = 32'hC; cyc("pushC", 32'h618, 0, 0, 0);
    stall = 1; branch_en_EX = 1; branch_EX = 32'h700;
    cyc("stall_pend", 32'h618, 0, 0, 0);
    rst = 1; stall = 1; branch_en_EX = 1; branch_EX = 32'h740; call_en = 1;
    cyc("reset_mid_stall", 32'h0, 0, 1, 0);
    rst = 0;
    cyc("after_reset", 32'h08, 0, 1, 0);
    ret_en = 1; cyc("after_reset_ret", 32'h10, 0, 1, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations never checked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
